// File: rtl/key_expansion_round.sv
// rtl/key_expansion_round.sv - iterative AES-128 key-schedule round, one shared S-box
//
// Purpose: holds the current AES-128 round key and advances it by one round
// per key_start pulse. The four SubWord bytes go through a single S-box, one
// byte per cycle, so each round takes 4 cycles.
//
// Ports:
//   clk        in   1    rising-edge clock
//   reset      in   1    asynchronous active-high reset
//   key_load   in   1    load key_in as the round-0 key (also aborts a round)
//   key_in     in   128  cipher key, w0 = [127:96] .. w3 = [31:0]
//   key_start  in   1    advance one round (sampled only while idle)
//   key_RC     in   32   round constant, byte in [31:24]
//   round_key  out  128  current round key, registered
//   key_done   out  1    one-cycle pulse when a new round_key is valid
//   key_busy   out  1    high while a round computation is in progress
module key_expansion_round (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_load,
    input  logic [127:0] key_in,
    input  logic         key_start,
    input  logic [31:0]  key_RC,
    output logic [127:0] round_key,
    output logic         key_done,
    output logic         key_busy
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SUB  = 1'b1;

    localparam logic [7:0] C_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic [0:0]   r_state;
    logic [1:0]   r_bi;
    logic [23:0]  r_tmp;
    logic [31:0]  r_rc;
    logic [127:0] r_key;
    logic         r_done;
    logic         r_busy;

    logic [31:0]  w_rot;
    logic [7:0]   w_sbox_in;
    logic [7:0]   w_sbox_out;
    logic [31:0]  w_t;
    logic [31:0]  w_w0n;
    logic [31:0]  w_w1n;
    logic [31:0]  w_w2n;
    logic [31:0]  w_w3n;

    // RotWord of the held w3; round_key is frozen during SUB so this is stable.
    assign w_rot = {r_key[23:0], r_key[31:24]};

    always_comb begin
        w_sbox_in = w_rot[31:24];
        case (r_bi)
            2'd0: w_sbox_in = w_rot[31:24];
            2'd1: w_sbox_in = w_rot[23:16];
            2'd2: w_sbox_in = w_rot[15:8];
            2'd3: w_sbox_in = w_rot[7:0];
            default: w_sbox_in = w_rot[31:24];
        endcase
    end

    assign w_sbox_out = C_SBOX[w_sbox_in];

    // Last byte comes straight from the S-box so the round closes on bi = 3.
    assign w_t   = {r_tmp, w_sbox_out} ^ r_rc;
    assign w_w0n = r_key[127:96] ^ w_t;
    assign w_w1n = r_key[95:64]  ^ w_w0n;
    assign w_w2n = r_key[63:32]  ^ w_w1n;
    assign w_w3n = r_key[31:0]   ^ w_w2n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_bi    <= 2'd0;
            r_tmp   <= 24'd0;
            r_rc    <= 32'd0;
            r_key   <= 128'd0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (key_load) begin
                // Load has priority over start and aborts any round in flight.
                r_key   <= key_in;
                r_state <= S_IDLE;
                r_bi    <= 2'd0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (key_start) begin
                            r_rc    <= key_RC;
                            r_state <= S_SUB;
                            r_bi    <= 2'd0;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_SUB: begin
                        if (r_bi == 2'd3) begin
                            r_key   <= {w_w0n, w_w1n, w_w2n, w_w3n};
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                            r_bi    <= 2'd0;
                            r_busy  <= 1'b0;
                        end else begin
                            case (r_bi)
                                2'd0: r_tmp[23:16] <= w_sbox_out;
                                2'd1: r_tmp[15:8]  <= w_sbox_out;
                                default: r_tmp[7:0] <= w_sbox_out;
                            endcase
                            r_bi <= r_bi + 2'd1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_bi    <= 2'd0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign round_key = r_key;
    assign key_done  = r_done;
    assign key_busy  = r_busy;

endmodule

// File: tb/tb_key_expansion_round.sv
// tb/tb_key_expansion_round.sv - scoreboard testbench for key_expansion_round
module tb_key_expansion_round;

    logic         clk;
    logic         reset;
    logic         key_load;
    logic [127:0] key_in;
    logic         key_start;
    logic [31:0]  key_RC;
    logic [127:0] round_key;
    logic         key_done;
    logic         key_busy;

    key_expansion_round dut (
        .clk       (clk),
        .reset     (reset),
        .key_load  (key_load),
        .key_in    (key_in),
        .key_start (key_start),
        .key_RC    (key_RC),
        .round_key (round_key),
        .key_done  (key_done),
        .key_busy  (key_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z1  = 128'h62636363626363636263636362636363;

    typedef struct {
        logic [127:0] key;
        bit           chk;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests;
    int   n_fail;
    int   n_done;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every key_done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && key_done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: key_done with empty scoreboard, round_key %h", round_key);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.chk) check("done_round_key", round_key, e.key);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [127:0] k);
        key_load = 1'b1;
        key_in   = k;
        tick();
        key_load = 1'b0;
    endtask

    // Start at edge k; returns just after edge k+4 with busy counted over 4 cycles.
    task automatic do_round(input logic [31:0] rc, input logic [127:0] exp_key, input bit chk);
        int nb;
        exp_t e;
        e.key = exp_key;
        e.chk = chk;
        exp_q.push_back(e);
        key_start = 1'b1;
        key_RC    = rc;
        tick();
        key_start = 1'b0;
        nb = 0;
        for (int i = 0; i < 4; i++) begin
            if (key_busy) nb++;
            tick();
        end
        check("busy_cycles", 128'(nb), 128'd4);
        check("busy_low_at_done", {127'd0, key_busy}, 128'd0);
    endtask

    logic [31:0] rc_tab [10];
    int d0;

    initial begin
        n_tests = 0; n_fail = 0; n_done = 0;
        rc_tab = '{32'h01000000, 32'h02000000, 32'h04000000, 32'h08000000, 32'h10000000,
                   32'h20000000, 32'h40000000, 32'h80000000, 32'h1b000000, 32'h36000000};
        reset = 1'b1; key_load = 1'b0; key_in = '0; key_start = 1'b0; key_RC = '0;
        repeat (3) tick();
        check("reset_round_key", round_key, 128'd0);
        check("reset_busy", {127'd0, key_busy}, 128'd0);
        check("reset_done", {127'd0, key_done}, 128'd0);
        reset = 1'b0;
        tick();

        // FIPS-197 rounds 1 and 2, back to back at the 5-cycle period.
        do_load(K0);
        check("load_key", round_key, K0);
        do_round(32'h01000000, K1, 1'b1);
        do_round(32'h02000000, K2, 1'b1);
        tick();
        check("after_r2", round_key, K2);

        // Full schedule, 10 starts every 5 cycles.
        do_load(K0);
        d0 = n_done;
        for (int r = 0; r < 10; r++)
            do_round(rc_tab[r], (r == 0) ? K1 : (r == 1) ? K2 : K10, (r == 0 || r == 1 || r == 9));
        tick();
        check("full_final_key", round_key, K10);
        check("full_done_count", 128'(n_done - d0), 128'd10);

        // Starts during SUB are ignored.
        do_load(K0);
        d0 = n_done;
        begin
            exp_t e;
            e.key = K1; e.chk = 1'b1;
            exp_q.push_back(e);
        end
        key_start = 1'b1; key_RC = 32'h01000000;
        tick();
        tick();
        tick();
        key_start = 1'b0;
        repeat (6) tick();
        check("ignore_start_key", round_key, K1);
        check("ignore_start_count", 128'(n_done - d0), 128'd1);

        // Load aborts a round in flight.
        do_load(K0);
        d0 = n_done;
        key_start = 1'b1; key_RC = 32'h01000000;
        tick();
        key_start = 1'b0;
        tick();
        key_load = 1'b1; key_in = '0;
        tick();
        key_load = 1'b0;
        check("abort_key", round_key, 128'd0);
        check("abort_busy", {127'd0, key_busy}, 128'd0);
        repeat (5) tick();
        check("abort_no_done", 128'(n_done - d0), 128'd0);

        // Load and start together in IDLE: load only.
        key_load = 1'b1; key_in = K0; key_start = 1'b1; key_RC = 32'h01000000;
        tick();
        key_load = 1'b0; key_start = 1'b0;
        check("load_start_key", round_key, K0);
        check("load_start_busy", {127'd0, key_busy}, 128'd0);
        repeat (5) tick();
        check("load_start_no_done", 128'(n_done - d0), 128'd0);
        check("load_start_key_held", round_key, K0);

        // RC changes during SUB have no effect.
        begin
            exp_t e;
            e.key = K1; e.chk = 1'b1;
            exp_q.push_back(e);
        end
        key_start = 1'b1; key_RC = 32'h01000000;
        tick();
        key_start = 1'b0; key_RC = 32'hffffffff;
        repeat (3) tick();
        key_RC = 32'h0;
        repeat (3) tick();
        check("rc_change_key", round_key, K1);

        // Asynchronous reset mid-SUB.
        do_load(K0);
        d0 = n_done;
        key_start = 1'b1; key_RC = 32'h01000000;
        tick();
        key_start = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        check("async_reset_key", round_key, 128'd0);
        check("async_reset_busy", {127'd0, key_busy}, 128'd0);
        check("async_reset_done", {127'd0, key_done}, 128'd0);
        tick();
        reset = 1'b0;
        repeat (6) tick();
        check("async_reset_no_done", 128'(n_done - d0), 128'd0);
        do_round(32'h01000000, Z1, 1'b1);
        tick();
        check("zero_key_round", round_key, Z1);

        repeat (2) tick();
        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
